// File: rtl/adler32_pkg.sv
// Shared constants for the Adler-32 stream transmitter and its accumulator.
// Includes the modular add used by both halves of the A/B update.
package adler32_pkg;

  localparam logic [16:0] ADLER_MOD    = 17'd65521;
  localparam logic [15:0] ADLER_INIT_A = 16'd1;
  localparam logic [15:0] ADLER_INIT_B = 16'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SIZE = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hFF;

  // Both operands are already reduced, so a single conditional subtract suffices.
  function automatic logic [15:0] adler_mod_add(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= ADLER_MOD) s = s - ADLER_MOD;
    return s[15:0];
  endfunction

endpackage

// File: rtl/adler32_accum.sv
// Registered Adler-32 A/B accumulator, one byte per enabled cycle.
// Shared between the transmitter reference and the receiver side.
import adler32_pkg::*;

module adler32_accum (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_sum
);

  logic [15:0] r_a, r_b;
  logic [15:0] w_a, w_b;

  assign w_a   = adler_mod_add(r_a, {8'd0, i_data});
  assign w_b   = adler_mod_add(r_b, w_a);
  assign o_sum = {r_b, r_a};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_a <= ADLER_INIT_A;
      r_b <= ADLER_INIT_B;
    end else if (i_en) begin
      r_a <= w_a;
      r_b <= w_b;
    end
  end

endmodule

// File: rtl/adler32_stream_tx.sv
// Frames a byte stream onto the Adler-32 generator and checks its response.
// Define ADLER_TX_LFSR_EN for LFSR payload; default payload counts down from N.
import adler32_pkg::*;

module adler32_stream_tx #(
  parameter int SIZE_W       = 22,
  parameter int RESP_TIMEOUT = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [SIZE_W-1:0] i_frame_size,
  output logic [SIZE_W-1:0] o_size,
  output logic              o_size_valid,
  output logic              o_data_start,
  output logic [7:0]        o_data,
  input  logic              i_checksum_valid,
  input  logic [31:0]       i_checksum,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic              o_spurious,
  output logic [31:0]       o_expected
);

  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [SIZE_W-1:0] r_size, r_cnt;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_size_valid, r_data_start, r_done, r_pass, r_timeout, r_spurious;
  logic [7:0]        r_data;
  logic [31:0]       r_expected;

  logic        w_accept, w_emit, w_win_end;
  logic [7:0]  w_byte;
  logic [31:0] w_sum;

  assign w_accept  = (r_state == ST_IDLE) && i_start && (i_frame_size != '0);
  // SIZE always emits byte 0; DATA emits until N bytes have gone out
  assign w_emit    = (r_state == ST_SIZE) || ((r_state == ST_DATA) && (r_cnt != r_size));
  assign w_win_end = (r_tmr == TMR_W'(RESP_TIMEOUT - 1));

`ifdef ADLER_TX_LFSR_EN
  logic [7:0] r_lfsr;

  assign w_byte = r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_lfsr <= LFSR_SEED;
    else if (w_accept) r_lfsr <= LFSR_SEED;
    else if (w_emit)   r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end
`else
  assign w_byte = 8'(r_size - r_cnt);
`endif

  adler32_accum u_accum (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_accept),
    .i_en    (w_emit),
    .i_data  (w_byte),
    .o_sum   (w_sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_size       <= '0;
      r_cnt        <= '0;
      r_tmr        <= '0;
      r_size_valid <= 1'b0;
      r_data_start <= 1'b0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_spurious   <= 1'b0;
      r_expected   <= '0;
    end else begin
      r_size_valid <= 1'b0;
      r_data_start <= 1'b0;
      r_done       <= 1'b0;
      if (i_checksum_valid && (r_state != ST_WAIT)) r_spurious <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_state      <= ST_SIZE;
          r_size       <= i_frame_size;
          r_size_valid <= 1'b1;
          r_cnt        <= '0;
          r_pass       <= 1'b0;
          r_timeout    <= 1'b0;
          r_spurious   <= i_checksum_valid;
        end
        ST_SIZE, ST_DATA: begin
          if (w_emit) begin
            r_state      <= ST_DATA;
            r_data       <= w_byte;
            r_data_start <= (r_state == ST_SIZE);
            r_cnt        <= r_cnt + SIZE_W'(1);
          end else begin
            r_state <= ST_WAIT;
            r_tmr   <= '0;
          end
        end
        ST_WAIT: begin
          if (i_checksum_valid || w_win_end) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_expected <= w_sum;
            r_pass     <= i_checksum_valid && (i_checksum == w_sum);
            r_timeout  <= !i_checksum_valid;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_size       = r_size;
  assign o_size_valid = r_size_valid;
  assign o_data_start = r_data_start;
  assign o_data       = r_data;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_timeout    = r_timeout;
  assign o_spurious   = r_spurious;
  assign o_expected   = r_expected;

endmodule

// File: tb/tb_adler32_stream_tx.sv
// Directed bench for adler32_stream_tx: scoreboarded frames against a
// software Adler-32 model, timeouts, spurious strobes and mid-frame reset.
module tb_adler32_stream_tx;

  localparam int SW = 22;
  localparam int RT = 10;

  logic          clk = 1'b0;
  logic          rst, start, cv;
  logic [SW-1:0] fsz;
  logic [31:0]   csum;
  logic [SW-1:0] o_size;
  logic          o_size_valid, o_data_start, o_busy, o_done, o_pass, o_timeout, o_spurious;
  logic [7:0]    o_data;
  logic [31:0]   o_expected;

  typedef struct packed {
    logic [31:0] exp;
    logic        pass;
    logic        to;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adler32_stream_tx #(.SIZE_W(SW), .RESP_TIMEOUT(RT)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_frame_size     (fsz),
    .o_size           (o_size),
    .o_size_valid     (o_size_valid),
    .o_data_start     (o_data_start),
    .o_data           (o_data),
    .i_checksum_valid (cv),
    .i_checksum       (csum),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_timeout        (o_timeout),
    .o_spurious       (o_spurious),
    .o_expected       (o_expected)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Advance one clock; return mid-cycle so sampling and driving stay off the edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model(input int n);
    int a, b;
    a = 1;
    b = 0;
    for (int k = 0; k < n; k++) begin
      a = a + ((n - k) & 255);
      if (a >= 65521) a = a - 65521;
      b = b + a;
      if (b >= 65521) b = b - 65521;
    end
    return (32'(b) << 16) | 32'(a);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_size"}, 32'(o_size), 0);
    chk({tag, "_size_valid"}, o_size_valid, 0);
    chk({tag, "_data_start"}, o_data_start, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_spurious"}, o_spurious, 0);
    chk({tag, "_expected"}, o_expected, 0);
  endtask

  // d = window cycle (1..RT) carrying the response, 0 = no response.
  task automatic run_frame(input int n, input int d, input bit corrupt, input bit poke_start);
    logic [31:0] e, resp;
    res_t        r;
    bit          got;
    int          got_w;
    e      = model(n);
    resp   = corrupt ? 32'h0 : e;
    r.exp  = e;
    r.pass = (d != 0) && !corrupt;
    r.to   = (d == 0);
    sb.push_back(r);

    start = 1'b1;
    fsz   = SW'(n);
    tick;
    start = 1'b0;
    chk("size_valid", o_size_valid, 1);
    chk("busy_c1", o_busy, 1);
    chk("size", 32'(o_size), 32'(n));
    chk("spurious_cleared", o_spurious, 0);
    if (poke_start) begin
      start = 1'b1;
      fsz   = SW'(9);
    end
    for (int k = 0; k < n; k++) begin
      tick;
      chk("data", o_data, 32'((n - k) & 255));
      chk("data_start", o_data_start, 32'(k == 0));
      if (k == 1) begin
        chk("size_held", 32'(o_size), 32'(n));
        chk("size_valid_pulse", o_size_valid, 0);
      end
    end
    start = 1'b0;

    got   = 1'b0;
    got_w = 0;
    for (int w = 1; w <= RT + 2 && !got; w++) begin
      tick;
      cv   = 1'b0;
      csum = '0;
      if (o_done) begin
        got   = 1'b1;
        got_w = w;
      end else if (w == d) begin
        cv   = 1'b1;
        csum = resp;
      end
    end
    cv = 1'b0;
    chk("done_cycle", 32'(got_w), 32'((d != 0) ? d + 1 : RT + 1));
    r = sb.pop_front();
    if (got) begin
      chk("expected", o_expected, r.exp);
      chk("pass", o_pass, 32'(r.pass));
      chk("timeout", o_timeout, 32'(r.to));
      chk("busy_done", o_busy, 1);
      chk("spurious_frame", o_spurious, 0);
      tick;
      chk("done_pulse", o_done, 0);
      chk("busy_idle", o_busy, 0);
    end
  endtask

  initial begin
    bit seen_done;
    rst   = 1'b1;
    start = 1'b0;
    cv    = 1'b0;
    csum  = '0;
    fsz   = '0;
    tick;
    tick;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick;

    run_frame(1, 2, 1'b0, 1'b0);
    chk("n1_expected_const", o_expected, 32'h00020002);
    run_frame(3, 1, 1'b0, 1'b0);
    chk("n3_expected_const", o_expected, 32'h00110007);
    run_frame(5, 0, 1'b0, 1'b0);
    run_frame(4, 3, 1'b1, 1'b1);
    run_frame(257, RT, 1'b0, 1'b0);
    run_frame(6000, 5, 1'b0, 1'b0);

    start = 1'b1;
    fsz   = '0;
    tick;
    start = 1'b0;
    chk("n0_busy", o_busy, 0);
    chk("n0_size_valid", o_size_valid, 0);
    tick;
    chk("n0_busy_later", o_busy, 0);

    cv = 1'b1;
    tick;
    cv = 1'b0;
    chk("spurious_idle", o_spurious, 1);
    tick;
    chk("spurious_sticky", o_spurious, 1);

    start = 1'b1;
    fsz   = SW'(10);
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk_reset_outputs("midreset");
    rst       = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (o_done) seen_done = 1'b1;
    end
    chk("midreset_no_done", seen_done, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
